// File: rtl/trace_scheduler_pkg.sv
// Shared types for the TAGE trace scheduler.
// Holds the state encoding, phase strobe bundle and default widths.
package tage_sched_pkg;

  localparam int ADDR_W_D  = 16;
  localparam int QUANT_W_D = 32;
  localparam int SWCNT_W_D = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_INDEX,
    ST_READ,
    ST_PREDICT,
    ST_UPDATE,
    ST_SWITCH,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic its;
    logic tre;
    logic upe;
    logic ue;
  } phase_t;

  localparam phase_t PH_NONE    = 4'b0000;
  localparam phase_t PH_INDEX   = 4'b1000;
  localparam phase_t PH_READ    = 4'b0100;
  localparam phase_t PH_PREDICT = 4'b0010;
  localparam phase_t PH_UPDATE  = 4'b0001;

  function automatic phase_t phase_of(state_t s);
    phase_t p;
    p = PH_NONE;
    unique case (s)
      ST_INDEX:   p = PH_INDEX;
      ST_READ:    p = PH_READ;
      ST_PREDICT: p = PH_PREDICT;
      ST_UPDATE:  p = PH_UPDATE;
      default:    p = PH_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/trace_scheduler_if.sv
// Control/status bundle between the scheduler and its host.
// The host drives run config; the scheduler drives memory and phase strobes.
interface trace_scheduler_if #(
  parameter int ADDR_W  = 16,
  parameter int QUANT_W = 32,
  parameter int SWCNT_W = 16
);

  logic               start;
  logic [QUANT_W-1:0] quantum;
  logic [ADDR_W-1:0]  last_addr1;
  logic [ADDR_W-1:0]  last_addr2;
  logic               en1;
  logic               en2;
  logic [ADDR_W-1:0]  addr1;
  logic [ADDR_W-1:0]  addr2;
  logic               sel;
  logic               index_tag_enable;
  logic               table_read_en;
  logic               update_predictor_enable;
  logic               update_enable;
  logic               busy;
  logic               done;
  logic [SWCNT_W-1:0] switch_count;

  modport master (
    output start, quantum,
    output last_addr1, last_addr2,
    input  en1, en2, addr1, addr2, sel,
    input  index_tag_enable, table_read_en,
    input  update_predictor_enable,
    input  update_enable,
    input  busy, done, switch_count
  );

  modport slave (
    input  start, quantum,
    input  last_addr1, last_addr2,
    output en1, en2, addr1, addr2, sel,
    output index_tag_enable, table_read_en,
    output update_predictor_enable,
    output update_enable,
    output busy, done, switch_count
  );

endinterface

// File: rtl/trace_scheduler_addr_ctr.sv
// Per-stream trace address counter.
// Counts up to its latched last address, then holds and flags done.
module trace_addr_ctr
  import tage_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              step,
  input  logic [ADDR_W-1:0] last_in,
  output logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic              hit
);

  logic [ADDR_W-1:0] last;

  assign hit = (addr == last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
      last <= '0;
      done <= 1'b0;
    end else if (clr) begin
      addr <= '0;
      last <= last_in;
      done <= 1'b0;
    end else if (step) begin
      // The final address is reused, never wrapped.
      if (hit) done <= 1'b1;
      else     addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/trace_scheduler.sv
// Deterministic sequencer for the TAGE datapath over two trace streams.
// Time-slices streams by quantum and walks each branch through 5 phases.
module trace_scheduler
  import tage_sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_D,
  parameter int QUANT_W = QUANT_W_D,
  parameter int SWCNT_W = SWCNT_W_D
) (
  input  logic             clk,
  input  logic             reset,
  trace_scheduler_if.slave bus
);

  state_t             state;
  state_t             state_nx;
  logic               sel;
  logic               sel_nx;
  logic [QUANT_W-1:0] slice;
  logic [QUANT_W-1:0] slice_nx;
  logic [QUANT_W-1:0] slice_inc;
  logic [QUANT_W-1:0] quant;
  logic [SWCNT_W-1:0] swcnt;
  phase_t             ph;
  logic               en1;
  logic               en2;
  logic               busy;
  logic               done;

  logic launch;
  logic step1;
  logic step2;
  logic hit1;
  logic hit2;
  logic d1;
  logic d2;
  logic nd1;
  logic nd2;
  logic cur_done;
  logic oth_done;
  logic at_q;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;

  assign launch = bus.start &&
                  (state == ST_IDLE ||
                   state == ST_DONE);

  assign step1 = (state == ST_UPDATE) && !sel;
  assign step2 = (state == ST_UPDATE) && sel;

  trace_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr1 (
    .clk     (clk),
    .reset   (reset),
    .clr     (launch),
    .step    (step1),
    .last_in (bus.last_addr1),
    .addr    (addr1),
    .done    (d1),
    .hit     (hit1)
  );

  trace_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr2 (
    .clk     (clk),
    .reset   (reset),
    .clr     (launch),
    .step    (step2),
    .last_in (bus.last_addr2),
    .addr    (addr2),
    .done    (d2),
    .hit     (hit2)
  );

  // Done flags as they will be after this UPDATE.
  assign nd1 = d1 | (step1 & hit1);
  assign nd2 = d2 | (step2 & hit2);

  assign cur_done  = sel ? nd2 : nd1;
  assign oth_done  = sel ? nd1 : nd2;
  assign slice_inc = slice + 1'b1;
  assign at_q      = (slice_inc == quant);

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    slice_nx = slice;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_nx = ST_FETCH;
          sel_nx   = 1'b0;
          slice_nx = '0;
        end
      end
      ST_FETCH:   state_nx = ST_INDEX;
      ST_INDEX:   state_nx = ST_READ;
      ST_READ:    state_nx = ST_PREDICT;
      ST_PREDICT: state_nx = ST_UPDATE;
      ST_UPDATE: begin
        slice_nx = slice_inc;
        if (nd1 && nd2) begin
          state_nx = ST_DONE;
        end else if (cur_done) begin
          state_nx = ST_SWITCH;
        end else if (at_q && !oth_done) begin
          state_nx = ST_SWITCH;
        end else if (at_q) begin
          slice_nx = '0;
          state_nx = ST_FETCH;
        end else begin
          state_nx = ST_FETCH;
        end
      end
      ST_SWITCH: begin
        sel_nx   = ~sel;
        slice_nx = '0;
        state_nx = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      slice <= '0;
      quant <= '0;
      swcnt <= '0;
      ph    <= PH_NONE;
      en1   <= 1'b0;
      en2   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      slice <= slice_nx;
      if (launch) begin
        swcnt <= '0;
        quant <= (bus.quantum == '0) ?
                 QUANT_W'(1) : bus.quantum;
      end else if (state == ST_SWITCH &&
                   swcnt != '1) begin
        swcnt <= swcnt + 1'b1;
      end
      // Outputs are the decode of the state being entered.
      ph   <= phase_of(state_nx);
      en1  <= (state_nx == ST_FETCH) && !sel_nx;
      en2  <= (state_nx == ST_FETCH) && sel_nx;
      busy <= (state_nx != ST_IDLE) &&
              (state_nx != ST_DONE);
      done <= (state_nx == ST_DONE);
    end
  end

  assign bus.en1   = en1;
  assign bus.en2   = en2;
  assign bus.addr1 = addr1;
  assign bus.addr2 = addr2;
  assign bus.sel   = sel;
  assign bus.busy  = busy;
  assign bus.done  = done;

  assign bus.index_tag_enable        = ph.its;
  assign bus.table_read_en           = ph.tre;
  assign bus.update_predictor_enable = ph.upe;
  assign bus.update_enable           = ph.ue;
  assign bus.switch_count            = swcnt;

endmodule

// File: tb/tb_trace_scheduler.sv
// Self-checking bench for trace_scheduler.
// A branch-level model expands each run into per-cycle expected outputs.
module tb_trace_scheduler;

  typedef struct packed {
    logic        en1;
    logic        en2;
    logic [15:0] a1;
    logic [15:0] a2;
    logic        sel;
    logic        its;
    logic        tre;
    logic        upe;
    logic        ue;
    logic        busy;
    logic        done;
    logic [15:0] swc;
  } vec_t;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  vec_t exp_q[$];
  int   model_br[$];
  int   fetch_log[$];
  int   lit[$];
  int   model_sw;

  trace_scheduler_if bus ();

  trace_scheduler u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t act();
    vec_t v;
    v.en1  = bus.en1;
    v.en2  = bus.en2;
    v.a1   = bus.addr1;
    v.a2   = bus.addr2;
    v.sel  = bus.sel;
    v.its  = bus.index_tag_enable;
    v.tre  = bus.table_read_en;
    v.upe  = bus.update_predictor_enable;
    v.ue   = bus.update_enable;
    v.busy = bus.busy;
    v.done = bus.done;
    v.swc  = bus.switch_count;
    return v;
  endfunction

  function automatic vec_t mk(
    input bit e1, input bit e2,
    input int a1, input int a2,
    input int s, input int ph,
    input bit bz, input bit dn,
    input int sw);
    vec_t v;
    v.en1  = e1;
    v.en2  = e2;
    v.a1   = 16'(a1);
    v.a2   = 16'(a2);
    v.sel  = s[0];
    v.its  = (ph == 1);
    v.tre  = (ph == 2);
    v.upe  = (ph == 3);
    v.ue   = (ph == 4);
    v.busy = bz;
    v.done = dn;
    v.swc  = 16'(sw);
    return v;
  endfunction

  task automatic chk(input string name,
                     input longint a,
                     input longint e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               name, a, e);
    end
  endtask

  // Spec-level model: branches and switches, one event at a time.
  task automatic build_model(input int q,
                             input int l1,
                             input int l2);
    int a[2];
    int lst[2];
    bit d[2];
    int s;
    int cnt;
    int sw;
    a[0] = 0; a[1] = 0;
    d[0] = 0; d[1] = 0;
    lst[0] = l1; lst[1] = l2;
    s = 0; cnt = 0; sw = 0;
    if (q == 0) q = 1;
    exp_q.delete();
    model_br.delete();
    forever begin
      model_br.push_back(s * 65536 + a[s]);
      for (int p = 0; p < 5; p++)
        exp_q.push_back(mk(p == 0 && s == 0,
                           p == 0 && s == 1,
                           a[0], a[1], s, p,
                           1'b1, 1'b0, sw));
      if (a[s] == lst[s]) d[s] = 1;
      else a[s]++;
      cnt++;
      if (d[0] && d[1]) break;
      if (d[s] || (cnt == q && !d[1-s])) begin
        exp_q.push_back(mk(0, 0, a[0], a[1], s, 0,
                           1'b1, 1'b0, sw));
        s = 1 - s;
        cnt = 0;
        sw++;
      end else if (cnt == q) begin
        cnt = 0;
      end
    end
    exp_q.push_back(mk(0, 0, a[0], a[1], s, 0,
                       1'b0, 1'b1, sw));
    model_sw = sw;
  endtask

  always @(negedge clk) begin : cmp
    vec_t e;
    vec_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act();
      nvec++;
      if (a !== e) begin
        nerr++;
        $display("FAIL cycle: got %h want %h",
                 a, e);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.en1 || bus.en2)
      fetch_log.push_back(
        (bus.sel ? 65536 : 0) +
        int'(bus.sel ? bus.addr2 : bus.addr1));
  end

  always @(negedge clk) begin
    if (reset && bus.busy) begin
      nvec++;
      if ($countones({bus.index_tag_enable,
                      bus.table_read_en,
                      bus.update_predictor_enable,
                      bus.update_enable}) > 1 ||
          (bus.en1 && bus.en2) ||
          ((bus.en1 || bus.en2) &&
           (bus.index_tag_enable ||
            bus.table_read_en ||
            bus.update_predictor_enable ||
            bus.update_enable))) begin
        nerr++;
        $display("FAIL strobe excl: %b%b %b%b%b%b",
                 bus.en1, bus.en2,
                 bus.index_tag_enable,
                 bus.table_read_en,
                 bus.update_predictor_enable,
                 bus.update_enable);
      end
    end
  end

  task automatic pulse(input int q,
                       input int l1,
                       input int l2);
    @(posedge clk);
    #2;
    bus.start      = 1'b1;
    bus.quantum    = q;
    bus.last_addr1 = 16'(l1);
    bus.last_addr2 = 16'(l2);
    @(posedge clk);
    #2;
    bus.start = 1'b0;
  endtask

  task automatic chk_list(input string name,
                          input int got[$]);
    chk({name, " len"}, got.size(), lit.size());
    if (got.size() == lit.size())
      foreach (lit[i])
        chk(name, got[i], lit[i]);
  endtask

  task automatic run(input string name,
                     input int q, input int l1,
                     input int l2, input int ghost,
                     input int cyc, input int sw);
    int n;
    pulse(q, l1, l2);
    fetch_log.delete();
    build_model(q, l1, l2);
    chk({name, " model cycles"},
        exp_q.size() - 1, cyc);
    chk({name, " model sw"}, model_sw, sw);
    chk_list({name, " model br"}, model_br);
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 2000) begin
      if (n == ghost) begin
        bus.start      = 1'b1;
        bus.quantum    = 7;
        bus.last_addr1 = 16'd9;
        bus.last_addr2 = 16'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk({name, " done cycle"}, n, cyc);
    @(negedge clk);
    chk({name, " leftover"}, exp_q.size(), 0);
    exp_q.delete();
    chk({name, " switch_count"},
        bus.switch_count, sw);
    chk({name, " done held"}, bus.done, 1);
    chk_list({name, " fetch seq"}, fetch_log);
  endtask

  initial begin : main
    int n;
    nvec = 0;
    nerr = 0;
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.quantum    = '0;
    bus.last_addr1 = '0;
    bus.last_addr2 = '0;
    #1;
    chk("reset state", act(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Abort a run in PREDICT.
    pulse(2, 3, 1);
    n = 0;
    while (!bus.update_predictor_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t1 reach predict",
        bus.update_predictor_enable, 1);
    reset = 1'b0;
    #1;
    chk("t1 async clear", act(), 0);
    repeat (2) begin
      @(negedge clk);
      chk("t1 held in reset", act(), 0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t1 idle after", act(), 0);
    end

    lit = '{0, 1, 65536, 65537, 2, 3};
    run("t2", 2, 3, 1, -1, 32, 2);

    lit = '{0, 65536, 1};
    run("t3", 0, 1, 0, -1, 17, 2);

    lit = '{0, 65536, 1, 2};
    run("t4", 1, 2, 0, 7, 22, 2);

    lit = '{0, 1, 65536, 65537, 65538};
    run("t5", 100, 1, 2, 3, 26, 1);

    repeat (4) @(negedge clk);
    chk("done idle hold", bus.done, 1);
    chk("done not busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
